// File: rtl/top_pkg.sv
// Shared constants, types and helpers for the 4x4 keypad scanner.
package top_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = 16;

  localparam int DEF_SCAN_CYCLES    = 120;
  localparam int DEF_DEBOUNCE_SCANS = 3;

  typedef logic [3:0]          key_idx_t;
  typedef logic [NUM_KEYS-1:0] key_vec_t;

  // Lowest set index wins when several keys go active together.
  function automatic key_idx_t lowest_key(input key_vec_t v);
    key_idx_t idx;
    idx = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = key_idx_t'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/top_matrix_scanner.sv
// Row drive, column synchronizers, per-row sampling and per-key debouncing
// for a 4x4 active-low key matrix.
module matrix_scanner
  import top_pkg::*;
#(
  parameter int SCAN_CYCLES    = DEF_SCAN_CYCLES,
  parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_COLS-1:0] cols,
  output logic [NUM_ROWS-1:0] rows,
  output key_vec_t            debounced
);

  localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_SCANS - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

  logic [NUM_COLS-1:0] col_meta_r;
  logic [NUM_COLS-1:0] col_sync_r;
  logic                active_r;
  logic [DW-1:0]       dwell_r;
  logic [1:0]          row_r;
  logic [NUM_ROWS-1:0] rows_r;
  key_vec_t            raw_r;
  key_vec_t            deb_r;
  logic [CW-1:0]       db_cnt_r  [NUM_KEYS];

  logic                sample_s;
  key_vec_t            raw_full_s;
  key_vec_t            deb_next_s;
  logic [CW-1:0]       cnt_next_s [NUM_KEYS];

  assign sample_s  = active_r && (dwell_r == DWELL_LAST);
  assign rows      = rows_r;
  assign debounced = deb_r;

  // Two-flop synchronizer; idle (pulled-up) level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_r <= 4'b1111;
      col_sync_r <= 4'b1111;
    end else begin
      col_meta_r <= cols;
      col_sync_r <= col_meta_r;
    end
  end

  // Row sequencer: the first cycle after reset starts a fresh row-0 dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= 1'b0;
      dwell_r  <= DW'(0);
      row_r    <= 2'd0;
      rows_r   <= 4'b1111;
    end else if (!active_r) begin
      active_r <= 1'b1;
      dwell_r  <= DW'(0);
      row_r    <= 2'd0;
      rows_r   <= 4'b1110;
    end else if (dwell_r == DWELL_LAST) begin
      dwell_r  <= DW'(0);
      row_r    <= row_r + 2'd1;
      rows_r   <= ~(4'b0001 << (row_r + 2'd1));
    end else begin
      dwell_r  <= dwell_r + DWELL_ONE;
    end
  end

  // Merge the active row's closed keys into the scan's raw vector.
  always_comb begin
    raw_full_s = raw_r;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (!col_sync_r[c]) begin
        raw_full_s[{row_r, 2'(c)}] = 1'b1;
      end else begin
        raw_full_s[{row_r, 2'(c)}] = raw_r[{row_r, 2'(c)}];
      end
    end
  end

  // Per-key debounce: flip only after DEBOUNCE_SCANS disagreeing scans in a row.
  always_comb begin
    deb_next_s = deb_r;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_next_s[k] = CNT_ZERO;
      if (raw_full_s[k] != deb_r[k]) begin
        if (db_cnt_r[k] == DB_LAST) begin
          deb_next_s[k] = ~deb_r[k];
          cnt_next_s[k] = CNT_ZERO;
        end else begin
          deb_next_s[k] = deb_r[k];
          cnt_next_s[k] = db_cnt_r[k] + CNT_ONE;
        end
      end else begin
        deb_next_s[k] = deb_r[k];
        cnt_next_s[k] = CNT_ZERO;
      end
    end
  end

  // Accumulate rows; the debounced state only moves when row 3 closes a scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_r <= 16'h0000;
      deb_r <= 16'h0000;
      for (int k = 0; k < NUM_KEYS; k++) begin
        db_cnt_r[k] <= CNT_ZERO;
      end
    end else if (sample_s) begin
      if (row_r == 2'd3) begin
        raw_r <= 16'h0000;
        deb_r <= deb_next_s;
        for (int k = 0; k < NUM_KEYS; k++) begin
          db_cnt_r[k] <= cnt_next_s[k];
        end
      end else begin
        raw_r <= raw_full_s;
      end
    end
  end

endmodule

// File: rtl/top.sv
// 4x4 keypad front end: scanner plus LED (any key held) and RGB (last key).
module top
  import top_pkg::*;
#(
  parameter int SCAN_CYCLES    = DEF_SCAN_CYCLES,
  parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic _39a,
  input  logic _38b,
  input  logic _41a,
  input  logic _42b,
  output logic _36b,
  output logic _37a,
  output logic _29b,
  output logic _31b,
  output logic LED,
  output logic RGB_R,
  output logic RGB_G,
  output logic RGB_B
);

  logic [NUM_COLS-1:0] cols_s;
  logic [NUM_ROWS-1:0] rows_s;
  key_vec_t            deb_s;
  key_vec_t            new_press_s;
  key_idx_t            new_key_s;

  key_vec_t            prev_deb_r;
  key_idx_t            last_key_r;
  logic                key_valid_r;
  logic                led_r;
  logic [2:0]          rgb_r;
  logic                unused_key_msb_s;

  assign cols_s = {_42b, _41a, _38b, _39a};

  matrix_scanner #(
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scanner (
    .clk       (clk),
    .rst_n     (rst_n),
    .cols      (cols_s),
    .rows      (rows_s),
    .debounced (deb_s)
  );

  assign {_31b, _29b, _37a, _36b} = rows_s;

  assign new_press_s = deb_s & ~prev_deb_r;
  assign new_key_s   = lowest_key(new_press_s);
  // RGB has only three channels; the index MSB is held but not displayed.
  assign unused_key_msb_s = last_key_r[3];

  // Press capture and LED; releases never touch the last-key register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_deb_r  <= 16'h0000;
      last_key_r  <= 4'd0;
      key_valid_r <= 1'b0;
      led_r       <= 1'b1;
      rgb_r       <= 3'b111;
    end else begin
      prev_deb_r <= deb_s;
      led_r      <= ~(|deb_s);
      if (|new_press_s) begin
        last_key_r  <= new_key_s;
        key_valid_r <= 1'b1;
      end
      rgb_r <= key_valid_r ? ~last_key_r[2:0] : 3'b111;
    end
  end

  assign LED   = led_r;
  assign RGB_R = rgb_r[0];
  assign RGB_G = rgb_r[1];
  assign RGB_B = rgb_r[2];

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the keypad scanner: directed vector table plus
// randomized hold patterns against a scan-level reference model.
module tb_top;

  localparam int S    = 120;
  localparam int D    = 3;
  localparam int SCAN = 4 * S;
  localparam int LAT  = (D + 1) * 4 * S + 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic c0, c1, c2, c3;
  logic r0, r1, r2, r3;
  logic led, rgb_r, rgb_g, rgb_b;

  top #(.SCAN_CYCLES(S), .DEBOUNCE_SCANS(D)) dut (
    .clk(clk), .rst_n(rst_n),
    ._39a(c0), ._38b(c1), ._41a(c2), ._42b(c3),
    ._36b(r0), ._37a(r1), ._29b(r2), ._31b(r3),
    .LED(led), .RGB_R(rgb_r), .RGB_G(rgb_g), .RGB_B(rgb_b)
  );

  // Key matrix: a held key pulls its column low while its row is driven low.
  logic [15:0] keys;
  logic [3:0]  rows_v, cols_v;
  assign rows_v = {r3, r2, r1, r0};
  assign {c3, c2, c1, c0} = cols_v;
  always_comb begin
    cols_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows_v[r] && keys[r*4+c]) cols_v[c] = 1'b0;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic logic [2:0] rgb_now();
    return {rgb_b, rgb_g, rgb_r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Returns one cycle-edge after row 0 starts a new dwell (i.e. a scan begins).
  task automatic wait_scan_start();
    logic prev;
    bit   found;
    prev  = r0;
    found = 1'b0;
    for (int i = 0; i < 2 * SCAN + 10; i++) begin
      @(posedge clk); #1;
      if (prev && !r0) begin
        found = 1'b1;
        break;
      end
      prev = r0;
    end
    check("scan_start_seen", found, 1);
  endtask

  task automatic wait_led(input string name, input logic exp);
    for (int i = 0; i < LAT; i++) begin
      if (led == exp) break;
      @(posedge clk); #1;
    end
    check(name, led, exp);
  endtask

  typedef struct {
    logic [15:0] keys;
    logic        exp_led;
    logic [2:0]  exp_rgb;   // {B,G,R}
  } vec_t;

  vec_t vecs[4];

  // Reference model state, updated once per completed scan.
  logic [15:0] deb_m;
  int          streak_m[16];
  int          last_m;

  task automatic model_scan(input logic [15:0] sample);
    logic [15:0] old;
    logic [15:0] rises;
    old = deb_m;
    for (int k = 0; k < 16; k++) begin
      if (sample[k] != deb_m[k]) begin
        streak_m[k]++;
        if (streak_m[k] >= D) begin
          deb_m[k]    = ~deb_m[k];
          streak_m[k] = 0;
        end
      end else begin
        streak_m[k] = 0;
      end
    end
    rises = deb_m & ~old;
    for (int k = 15; k >= 0; k--)
      if (rises[k]) last_m = k;
  endtask

  initial begin
    logic [15:0] pat;
    logic [15:0] one;
    logic [2:0]  exp_rgb;
    logic [3:0]  lk;
    bit          low_seen;
    int          n;

    one   = 16'h0001;
    keys  = 16'h0000;
    rst_n = 1'b0;
    vecs[0] = '{16'h0020, 1'b0, 3'b010};  // key 5
    vecs[1] = '{16'h0000, 1'b1, 3'b010};  // release 5
    vecs[2] = '{16'h0400, 1'b0, 3'b101};  // key 10
    vecs[3] = '{16'h0000, 1'b1, 3'b101};  // release 10

    repeat (3) @(posedge clk); #1;
    check("reset_rows", rows_v, 4'hF);
    check("reset_led", led, 1);
    check("reset_rgb", rgb_now(), 3'b111);

    // Idle scanning: one row low at a time, 120 cycles each.
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("row0_first", rows_v, 4'b1110);
    repeat (S - 1) @(posedge clk); #1;
    check("row0_last", rows_v, 4'b1110);
    @(posedge clk); #1;
    check("row1", rows_v, 4'b1101);
    repeat (S) @(posedge clk); #1;
    check("row2", rows_v, 4'b1011);
    repeat (S) @(posedge clk); #1;
    check("row3", rows_v, 4'b0111);
    repeat (S) @(posedge clk); #1;
    check("row_wrap", rows_v, 4'b1110);
    check("idle_led", led, 1);
    check("idle_rgb", rgb_now(), 3'b111);

    for (int i = 0; i < 4; i++) begin
      wait_scan_start();
      keys = vecs[i].keys;
      wait_led($sformatf("vec%0d_led", i), vecs[i].exp_led);
      repeat (4) @(posedge clk); #1;
      check($sformatf("vec%0d_rgb", i), rgb_now(), vecs[i].exp_rgb);
    end

    // Key 3 closed for exactly one scan must be filtered out.
    wait_scan_start();
    keys = 16'h0008;
    wait_scan_start();
    keys = 16'h0000;
    low_seen = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      @(posedge clk); #1;
      if (!led) low_seen = 1'b1;
    end
    check("glitch_led_low", low_seen, 0);
    check("glitch_rgb", rgb_now(), 3'b101);

    // Keys 6 and 9 together: lowest index is reported.
    wait_scan_start();
    keys = 16'h0240;
    wait_led("dual_led", 1'b0);
    repeat (4) @(posedge clk); #1;
    check("dual_rgb", rgb_now(), 3'b001);

    // Reset mid-hold takes effect without waiting for a clock.
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("midrst_rows", rows_v, 4'hF);
    check("midrst_led", led, 1);
    check("midrst_rgb", rgb_now(), 3'b111);
    keys = 16'h0000;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("restart_row0", rows_v, 4'b1110);

    // Randomized hold patterns against the scan-level model.
    deb_m  = 16'h0000;
    last_m = -1;
    for (int k = 0; k < 16; k++) streak_m[k] = 0;
    pat = 16'h0000;
    for (int step = 0; step < 25; step++) begin
      case ($urandom_range(0, 3))
        0: pat = 16'h0000;
        1: pat = one << $urandom_range(0, 15);
        2: pat = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
        default: pat = pat;
      endcase
      keys = pat;
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        wait_scan_start();
        model_scan(pat);
        repeat (3) @(posedge clk); #1;
        lk = 4'(last_m);
        exp_rgb = (last_m < 0) ? 3'b111 : ~lk[2:0];
        check($sformatf("rand%0d_led", step), led, (deb_m == 16'h0000));
        check($sformatf("rand%0d_rgb", step), rgb_now(), exp_rgb);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
